mem_access_stage: RTL and testbench

- MEM pipeline stage sitting directly downstream of the EX/MEM pipeline register.
- Consumes the registered EX results (address, store data, size, sign, control) and drives a variable-latency data-memory bus with a req/ack handshake.
- Aligns and extends load data, then presents a registered result to the MEM/WB register.
- Stalls the upstream pipeline while a memory access is outstanding.

---
 rtl/mem_pkg.sv | 35 +++
 rtl/mem_load_align.sv | 51 +++++
 rtl/mem_access_stage.sv | 178 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared encodings, control-bit positions and FSM type for the
//               MEM pipeline stage.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam logic [1:0] LS_BYTE    = 2'b00;
    localparam logic [1:0] LS_HALF    = 2'b01;
    localparam logic [1:0] LS_WORD    = 2'b10;
    localparam logic [1:0] LS_ILLEGAL = 2'b11;

    localparam int CTRL_REG_WRITE = 0;
    localparam int CTRL_MEM_READ  = 4;
    localparam int CTRL_MEM_WRITE = 5;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Natural alignment check; the illegal size code is always rejected.
    function automatic logic is_misaligned(input logic [1:0] ls, input logic [1:0] addr_lo);
        case (ls)
            LS_BYTE: is_misaligned = 1'b0;
            LS_HALF: is_misaligned = addr_lo[0];
            LS_WORD: is_misaligned = (addr_lo != 2'b00);
            default: is_misaligned = 1'b1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_load_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_load_align
// Description : Byte-lane steering: load extraction/extension plus the
//               matching byte enables and replicated store data.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [31:0] i_store_data,
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_ls,
    input  logic        i_sign_flag,
    output logic [31:0] o_load_data,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        o_load_data = i_rdata;
        o_be        = 4'b1111;
        o_wdata     = i_store_data;
        case (i_ls)
            LS_BYTE: begin
                o_load_data = {{24{i_sign_flag & w_byte[7]}}, w_byte};
                o_be        = 4'b0001 << i_addr_lo;
                o_wdata     = {4{i_store_data[7:0]}};
            end
            LS_HALF: begin
                o_load_data = {{16{i_sign_flag & w_half[15]}}, w_half};
                o_be        = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata     = {2{i_store_data[15:0]}};
            end
            default: begin
                o_load_data = i_rdata;
                o_be        = 4'b1111;
                o_wdata     = i_store_data;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : MEM pipeline stage driving a req/ack data bus, stalling the
//               upstream pipe while an access is outstanding.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [XLEN-1:0] in_pc,
    input  logic [4:0]      in_reg_addr,
    input  logic [7:0]      in_control,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_write_data,
    input  logic [1:0]      in_ls,
    input  logic            in_sign_flag,
    output logic            stall,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_be,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_reg_addr,
    output logic [7:0]      out_control,
    output logic [XLEN-1:0] out_wb_data,
    output logic            out_misalign
);

    state_t          r_state;
    state_t          w_next_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_store_data;
    logic [4:0]      r_reg_addr;
    logic [7:0]      r_control;
    logic [1:0]      r_ls;
    logic            r_sign;
    logic            r_we;

    logic            w_busy;
    logic            w_mem_op;
    logic            w_misalign;
    logic            w_accept;
    logic            w_fire;
    logic            w_fire_mis;
    logic [XLEN-1:0] w_fire_pc;
    logic [4:0]      w_fire_rd;
    logic [7:0]      w_fire_ctrl;
    logic [XLEN-1:0] w_fire_wb;
    logic [31:0]     w_load_data;
    logic [3:0]      w_lane_be;
    logic [31:0]     w_lane_wdata;

    assign w_busy     = (r_state == BUSY);
    assign w_mem_op   = in_control[CTRL_MEM_READ] | in_control[CTRL_MEM_WRITE];
    assign w_misalign = is_misaligned(in_ls, in_alu_result[1:0]);

    mem_load_align u_align (
        .i_rdata      (dmem_rdata),
        .i_store_data (r_store_data),
        .i_addr_lo    (r_addr[1:0]),
        .i_ls         (r_ls),
        .i_sign_flag  (r_sign),
        .o_load_data  (w_load_data),
        .o_be         (w_lane_be),
        .o_wdata      (w_lane_wdata)
    );

    // Bus signals decode only registered state, so reset drops them at once.
    assign stall      = w_busy;
    assign dmem_req   = w_busy;
    assign dmem_we    = w_busy & r_we;
    assign dmem_addr  = w_busy ? {r_addr[XLEN-1:2], 2'b00} : '0;
    assign dmem_be    = w_busy ? w_lane_be : 4'b0000;
    assign dmem_wdata = w_busy ? w_lane_wdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_fire       = 1'b0;
        w_fire_mis   = 1'b0;
        w_fire_pc    = in_pc;
        w_fire_rd    = in_reg_addr;
        w_fire_ctrl  = in_control;
        w_fire_wb    = in_alu_result;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    if (!w_mem_op) begin
                        w_fire = 1'b1;
                    end else if (w_misalign) begin
                        w_fire                      = 1'b1;
                        w_fire_mis                  = 1'b1;
                        w_fire_wb                   = '0;
                        w_fire_ctrl[CTRL_REG_WRITE] = 1'b0;
                    end else begin
                        w_accept     = 1'b1;
                        w_next_state = BUSY;
                    end
                end
            end
            BUSY: begin
                if (dmem_ack) begin
                    w_next_state = IDLE;
                    w_fire       = 1'b1;
                    w_fire_pc    = r_pc;
                    w_fire_rd    = r_reg_addr;
                    w_fire_ctrl  = r_control;
                    w_fire_wb    = r_we ? r_addr : w_load_data;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc         <= '0;
            r_addr       <= '0;
            r_store_data <= '0;
            r_reg_addr   <= '0;
            r_control    <= '0;
            r_ls         <= LS_BYTE;
            r_sign       <= 1'b0;
            r_we         <= 1'b0;
        end else if (w_accept) begin
            r_pc         <= in_pc;
            r_addr       <= in_alu_result;
            r_store_data <= in_write_data;
            r_reg_addr   <= in_reg_addr;
            r_control    <= in_control;
            r_ls         <= in_ls;
            r_sign       <= in_sign_flag;
            r_we         <= in_control[CTRL_MEM_WRITE];
        end
    end

    // Result fields hold between pulses; only out_valid is a strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_reg_addr <= '0;
            out_control  <= '0;
            out_wb_data  <= '0;
            out_misalign <= 1'b0;
        end else begin
            out_valid <= w_fire;
            if (w_fire) begin
                out_pc       <= w_fire_pc;
                out_reg_addr <= w_fire_rd;
                out_control  <= w_fire_ctrl;
                out_wb_data  <= w_fire_wb;
                out_misalign <= w_fire_mis;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_stage
// Description : Self-checking bench: directed vector table, random ops against
//               a behavioural model, and a reset-during-access sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [4:0]  in_reg_addr;
    logic [7:0]  in_control;
    logic [31:0] in_alu_result;
    logic [31:0] in_write_data;
    logic [1:0]  in_ls;
    logic        in_sign_flag;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [4:0]  out_reg_addr;
    logic [7:0]  out_control;
    logic [31:0] out_wb_data;
    logic        out_misalign;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.XLEN(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_pc         (in_pc),
        .in_reg_addr   (in_reg_addr),
        .in_control    (in_control),
        .in_alu_result (in_alu_result),
        .in_write_data (in_write_data),
        .in_ls         (in_ls),
        .in_sign_flag  (in_sign_flag),
        .stall         (stall),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_be       (dmem_be),
        .dmem_ack      (dmem_ack),
        .dmem_rdata    (dmem_rdata),
        .out_valid     (out_valid),
        .out_pc        (out_pc),
        .out_reg_addr  (out_reg_addr),
        .out_control   (out_control),
        .out_wb_data   (out_wb_data),
        .out_misalign  (out_misalign)
    );

    typedef struct {
        logic [7:0]  ctrl;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [1:0]  ls;
        logic        sign;
        logic [31:0] rdata;
        int          delay;
        logic        e_mem;
        logic        e_we;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_wb;
        logic        e_mis;
        logic [7:0]  e_ctrl;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: sizes in bytes, lanes by shifting, extension by masking.
    function automatic void model(input logic [7:0] ctrl, input logic [31:0] addr,
                                  input logic [31:0] wd, input logic [1:0] ls,
                                  input logic sign, input logic [31:0] rdata,
                                  output logic mem, output logic we,
                                  output logic [3:0] be, output logic [31:0] wdata,
                                  output logic [31:0] wb, output logic mis,
                                  output logic [7:0] octrl);
        int          size;
        int          off;
        logic [63:0] mask;
        logic [63:0] v;
        mem   = ctrl[4] | ctrl[5];
        we    = ctrl[5];
        off   = int'(addr % 4);
        size  = (ls == 2'd0) ? 1 : (ls == 2'd1) ? 2 : 4;
        mis   = mem && (ls == 2'd3 || (off % size) != 0);
        be    = 4'(((1 << size) - 1) << off);
        mask  = (64'd1 << (8 * size)) - 64'd1;
        wdata = (size == 1) ? 32'(wd[7:0]) * 32'h0101_0101 :
                (size == 2) ? 32'(wd[15:0]) * 32'h0001_0001 : wd;
        v     = ({32'b0, rdata} >> (8 * off)) & mask;
        if (sign && v[8 * size - 1]) v = v | ~mask;
        octrl = ctrl;
        wb    = addr;
        if (mem) begin
            if (mis) begin
                wb    = 32'h0;
                octrl = ctrl & 8'hFE;
            end else if (!we) begin
                wb = v[31:0];
            end
        end
    endfunction

    // Entered and left at a negedge.
    task automatic do_op(input string nm, input logic [7:0] ctrl, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [1:0] ls, input logic sign,
                         input logic [31:0] rdata, input int delay,
                         input logic e_mem, input logic e_we, input logic [3:0] e_be,
                         input logic [31:0] e_wdata, input logic [31:0] e_wb,
                         input logic e_mis, input logic [7:0] e_ctrl);
        logic [31:0] pc;
        logic [4:0]  rd;
        pc            = $urandom;
        rd            = 5'($urandom);
        in_valid      = 1'b1;
        in_pc         = pc;
        in_reg_addr   = rd;
        in_control    = ctrl;
        in_alu_result = addr;
        in_write_data = wd;
        in_ls         = ls;
        in_sign_flag  = sign;
        @(negedge clk);
        in_valid = 1'b0;
        if (e_mem && !e_mis) begin
            chk({nm, ".accept_valid"}, 32'(out_valid), 32'd0);
            for (int i = 1; i <= delay; i++) begin
                chk({nm, ".stall"}, 32'(stall), 32'd1);
                chk({nm, ".req"}, 32'(dmem_req), 32'd1);
                chk({nm, ".we"}, 32'(dmem_we), 32'(e_we));
                chk({nm, ".addr"}, dmem_addr, {addr[31:2], 2'b00});
                chk({nm, ".be"}, 32'(dmem_be), 32'(e_be));
                chk({nm, ".wdata"}, dmem_wdata, e_wdata);
                in_valid      = 1'($urandom);
                in_pc         = $urandom;
                in_control    = 8'($urandom);
                in_alu_result = $urandom;
                in_ls         = 2'($urandom);
                if (i == delay) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = rdata;
                end else begin
                    dmem_rdata = $urandom;
                end
                @(negedge clk);
            end
            dmem_ack   = 1'b0;
            dmem_rdata = $urandom;
            in_valid   = 1'b0;
        end
        chk({nm, ".valid"}, 32'(out_valid), 32'd1);
        chk({nm, ".wb"}, out_wb_data, e_wb);
        chk({nm, ".misalign"}, 32'(out_misalign), 32'(e_mis));
        chk({nm, ".ctrl"}, 32'(out_control), 32'(e_ctrl));
        chk({nm, ".pc"}, out_pc, pc);
        chk({nm, ".rd"}, 32'(out_reg_addr), 32'(rd));
        chk({nm, ".stall_after"}, 32'(stall), 32'd0);
        chk({nm, ".req_after"}, 32'(dmem_req), 32'd0);
        @(negedge clk);
        chk({nm, ".idle_valid"}, 32'(out_valid), 32'd0);
        chk({nm, ".wb_hold"}, out_wb_data, e_wb);
    endtask

    initial begin
        tbl[0]  = '{8'h01, 32'h1234_5678, 32'h0, 2'b10, 1'b0, 32'h0, 1,
                    1'b0, 1'b0, 4'h0, 32'h0, 32'h1234_5678, 1'b0, 8'h01};
        tbl[1]  = '{8'h11, 32'h103, 32'h0, 2'b00, 1'b1, 32'h80AA_BBCC, 3,
                    1'b1, 1'b0, 4'b1000, 32'h0, 32'hFFFF_FF80, 1'b0, 8'h11};
        tbl[2]  = '{8'h11, 32'h202, 32'h0, 2'b01, 1'b0, 32'h8001_7FFF, 1,
                    1'b1, 1'b0, 4'b1100, 32'h0, 32'h0000_8001, 1'b0, 8'h11};
        tbl[3]  = '{8'h20, 32'h301, 32'hA5, 2'b00, 1'b0, 32'h0, 2,
                    1'b1, 1'b1, 4'b0010, 32'hA5A5_A5A5, 32'h301, 1'b0, 8'h20};
        tbl[4]  = '{8'h11, 32'h402, 32'h0, 2'b10, 1'b0, 32'h0, 1,
                    1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 8'h10};
        tbl[5]  = '{8'h11, 32'h400, 32'h0, 2'b11, 1'b0, 32'h0, 1,
                    1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 8'h10};
        tbl[6]  = '{8'h21, 32'h500, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'h0, 1,
                    1'b1, 1'b1, 4'hF, 32'hDEAD_BEEF, 32'h500, 1'b0, 8'h21};
        tbl[7]  = '{8'h11, 32'h206, 32'h0, 2'b01, 1'b1, 32'h8001_7FFF, 2,
                    1'b1, 1'b0, 4'b1100, 32'h0, 32'hFFFF_8001, 1'b0, 8'h11};
        tbl[8]  = '{8'h31, 32'h600, 32'h0000_1234, 2'b01, 1'b0, 32'hFFFF_FFFF, 1,
                    1'b1, 1'b1, 4'b0011, 32'h1234_1234, 32'h600, 1'b0, 8'h31};
        tbl[9]  = '{8'h11, 32'h101, 32'h0, 2'b00, 1'b0, 32'h80AA_BBCC, 1,
                    1'b1, 1'b0, 4'b0010, 32'h0, 32'h0000_00BB, 1'b0, 8'h11};
        tbl[10] = '{8'h11, 32'h203, 32'h0, 2'b01, 1'b0, 32'h0, 1,
                    1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 8'h10};

        rst           = 1'b1;
        in_valid      = 1'b0;
        in_pc         = '0;
        in_reg_addr   = '0;
        in_control    = '0;
        in_alu_result = '0;
        in_write_data = '0;
        in_ls         = '0;
        in_sign_flag  = 1'b0;
        dmem_ack      = 1'b0;
        dmem_rdata    = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset.valid", 32'(out_valid), 32'd0);
        chk("reset.stall", 32'(stall), 32'd0);
        chk("reset.req", 32'(dmem_req), 32'd0);
        chk("reset.wb", out_wb_data, 32'd0);
        chk("reset.misalign", 32'(out_misalign), 32'd0);
        chk("reset.be", 32'(dmem_be), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            do_op($sformatf("vec%0d", i), tbl[i].ctrl, tbl[i].addr, tbl[i].wd, tbl[i].ls,
                  tbl[i].sign, tbl[i].rdata, tbl[i].delay, tbl[i].e_mem, tbl[i].e_we,
                  tbl[i].e_be, tbl[i].e_wdata, tbl[i].e_wb, tbl[i].e_mis, tbl[i].e_ctrl);
        end

        for (int n = 0; n < 150; n++) begin
            logic [7:0]  c;
            logic [31:0] a;
            logic [31:0] wd;
            logic [1:0]  ls;
            logic        sg;
            logic [31:0] rd;
            logic        m_mem, m_we, m_mis;
            logic [3:0]  m_be;
            logic [31:0] m_wdata, m_wb;
            logic [7:0]  m_ctrl;
            c    = 8'($urandom);
            c[4] = 1'($urandom);
            c[5] = 1'($urandom);
            a    = $urandom;
            wd   = $urandom;
            ls   = 2'($urandom_range(0, 3));
            sg   = 1'($urandom);
            rd   = $urandom;
            model(c, a, wd, ls, sg, rd, m_mem, m_we, m_be, m_wdata, m_wb, m_mis, m_ctrl);
            do_op($sformatf("rnd%0d", n), c, a, wd, ls, sg, rd, int'($urandom_range(1, 4)),
                  m_mem, m_we, m_be, m_wdata, m_wb, m_mis, m_ctrl);
        end

        // Leave out_misalign set, then reset in the middle of an access.
        do_op("pre_rst", 8'h11, 32'h702, 32'h0, 2'b10, 1'b0, 32'h0, 1,
              1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 8'h10);
        in_valid      = 1'b1;
        in_control    = 8'h11;
        in_alu_result = 32'h0000_0804;
        in_ls         = 2'b10;
        in_pc         = 32'h0000_4444;
        @(negedge clk);
        in_valid = 1'b0;
        chk("midrst.stall_before", 32'(stall), 32'd1);
        chk("midrst.misalign_hold", 32'(out_misalign), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst.req", 32'(dmem_req), 32'd0);
        chk("midrst.stall", 32'(stall), 32'd0);
        chk("midrst.addr", dmem_addr, 32'd0);
        chk("midrst.be", 32'(dmem_be), 32'd0);
        chk("midrst.misalign", 32'(out_misalign), 32'd0);
        chk("midrst.ctrl", 32'(out_control), 32'd0);
        chk("midrst.pc", out_pc, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        dmem_ack = 1'b0;
        chk("stray_ack.valid", 32'(out_valid), 32'd0);
        chk("stray_ack.stall", 32'(stall), 32'd0);
        chk("stray_ack.req", 32'(dmem_req), 32'd0);
        chk("stray_ack.wb", out_wb_data, 32'd0);
        @(negedge clk);
        chk("stray_ack.valid2", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
